// File: rtl/dispatch_buffer_if.sv
// Dispatch-to-issue-slot bus for dispatch_buffer: uop handshake from dispatch on one side,
// head payload and per-slot write strobes toward the issue slots on the other.
interface dispatch_buffer_if #(
   parameter int NUM_SLOTS = 8
);
   logic                 io_dis_valid;
   logic                 io_dis_ready;
   logic [6:0]           io_dis_uop_pdst;
   logic [6:0]           io_dis_uop_prs1;
   logic [6:0]           io_dis_uop_prs2;
   logic                 io_dis_uop_prs1_busy;
   logic                 io_dis_uop_prs2_busy;
   logic [11:0]          io_dis_uop_br_mask;
   logic [NUM_SLOTS-1:0] io_slot_valid;
   logic [NUM_SLOTS-1:0] io_slot_we;
   logic [6:0]           io_out_uop_pdst;
   logic [6:0]           io_out_uop_prs1;
   logic [6:0]           io_out_uop_prs2;
   logic                 io_out_uop_prs1_busy;
   logic                 io_out_uop_prs2_busy;
   logic [11:0]          io_out_uop_br_mask;

   modport master (
      output io_dis_valid, io_dis_uop_pdst, io_dis_uop_prs1, io_dis_uop_prs2,
             io_dis_uop_prs1_busy, io_dis_uop_prs2_busy, io_dis_uop_br_mask, io_slot_valid,
      input  io_dis_ready, io_slot_we, io_out_uop_pdst, io_out_uop_prs1, io_out_uop_prs2,
             io_out_uop_prs1_busy, io_out_uop_prs2_busy, io_out_uop_br_mask
   );

   modport slave (
      input  io_dis_valid, io_dis_uop_pdst, io_dis_uop_prs1, io_dis_uop_prs2,
             io_dis_uop_prs1_busy, io_dis_uop_prs2_busy, io_dis_uop_br_mask, io_slot_valid,
      output io_dis_ready, io_slot_we, io_out_uop_pdst, io_out_uop_prs1, io_out_uop_prs2,
             io_out_uop_prs1_busy, io_out_uop_prs2_busy, io_out_uop_br_mask
   );
endinterface

// File: rtl/dispatch_buffer.sv
// In-order uop buffer feeding the lowest free issue slot, with wakeup snooping and branch-mask clearing.
// Optional DISPATCH_BUFFER_STALL_CNT_EN adds io_stall_cnt (cycles the head waited on full slots).
module dispatch_buffer #(
   parameter int DEPTH     = 4,
   parameter int NUM_SLOTS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_kill,
   input  logic [11:0]              io_brupdate_resolve_mask,
   input  logic                     io_wakeup_ports_0_valid,
   input  logic [6:0]               io_wakeup_ports_0_bits_pdst,
   input  logic                     io_wakeup_ports_1_valid,
   input  logic [6:0]               io_wakeup_ports_1_bits_pdst,
   dispatch_buffer_if.slave         bus,
   output logic [$clog2(DEPTH):0]   io_count
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
   ,
   output logic [15:0]              io_stall_cnt
`endif
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] head_q, tail_q;
   logic [IDX_W-1:0] head_idx, tail_idx;
   logic             empty, full, push, pop, slots_full;

   logic [6:0]       pdst_q      [DEPTH];
   logic [6:0]       prs1_q      [DEPTH];
   logic [6:0]       prs2_q      [DEPTH];
   logic             prs1_busy_q [DEPTH];
   logic             prs2_busy_q [DEPTH];
   logic [11:0]      br_mask_q   [DEPTH];

   logic [DEPTH-1:0] wake1, wake2;
   logic             in_wake1, in_wake2;
   logic [NUM_SLOTS-1:0] free_onehot;

   function automatic logic woken(input logic [6:0] prs, input logic v0, input logic [6:0] p0,
                                  input logic v1, input logic [6:0] p1);
      return (v0 && (p0 == prs)) || (v1 && (p1 == prs));
   endfunction

   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];
   assign empty      = (head_q == tail_q);
   assign full       = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
   assign slots_full = &bus.io_slot_valid;
   assign push       = bus.io_dis_valid && !full && !io_kill;
   assign pop        = !empty && !slots_full && !io_kill;

   // Isolate the lowest zero bit of io_slot_valid.
   assign free_onehot    = ~bus.io_slot_valid & (bus.io_slot_valid + NUM_SLOTS'(1));
   assign bus.io_slot_we = pop ? free_onehot : '0;
   assign bus.io_dis_ready = !full;
   assign io_count       = tail_q - head_q;

   always_comb begin
      wake1 = '0;
      wake2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wake1[i] = woken(prs1_q[i], io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
                          io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst);
         wake2[i] = woken(prs2_q[i], io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
                          io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst);
      end
   end

   assign in_wake1 = woken(bus.io_dis_uop_prs1, io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
                           io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst);
   assign in_wake2 = woken(bus.io_dis_uop_prs2, io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
                           io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else if (io_kill) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
      end
   end

   // Payload is not reset; outputs are gated by empty so stale contents never leak.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         br_mask_q[i] <= br_mask_q[i] & ~io_brupdate_resolve_mask;
         if (wake1[i]) prs1_busy_q[i] <= 1'b0;
         if (wake2[i]) prs2_busy_q[i] <= 1'b0;
         if (push && (tail_idx == IDX_W'(i))) begin
            pdst_q[i]      <= bus.io_dis_uop_pdst;
            prs1_q[i]      <= bus.io_dis_uop_prs1;
            prs2_q[i]      <= bus.io_dis_uop_prs2;
            prs1_busy_q[i] <= bus.io_dis_uop_prs1_busy && !in_wake1;
            prs2_busy_q[i] <= bus.io_dis_uop_prs2_busy && !in_wake2;
            br_mask_q[i]   <= bus.io_dis_uop_br_mask & ~io_brupdate_resolve_mask;
         end
      end
   end

   assign bus.io_out_uop_pdst      = empty ? '0 : pdst_q[head_idx];
   assign bus.io_out_uop_prs1      = empty ? '0 : prs1_q[head_idx];
   assign bus.io_out_uop_prs2      = empty ? '0 : prs2_q[head_idx];
   assign bus.io_out_uop_prs1_busy = !empty && prs1_busy_q[head_idx] && !wake1[head_idx];
   assign bus.io_out_uop_prs2_busy = !empty && prs2_busy_q[head_idx] && !wake2[head_idx];
   assign bus.io_out_uop_br_mask   = empty ? '0 : (br_mask_q[head_idx] & ~io_brupdate_resolve_mask);

`ifdef DISPATCH_BUFFER_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_stall_cnt <= '0;
      end else if (io_kill) begin
         io_stall_cnt <= '0;
      end else if (!empty && slots_full && (io_stall_cnt != 16'hFFFF)) begin
         io_stall_cnt <= io_stall_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_dispatch_buffer;
   localparam int DEPTH     = 4;
   localparam int NUM_SLOTS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_kill;
   logic [11:0] io_brupdate_resolve_mask;
   logic        w0v, w1v;
   logic [6:0]  w0p, w1p;
   logic [2:0]  io_count;
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
   logic [15:0] io_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit run     = 1'b0;

   dispatch_buffer_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

   dispatch_buffer #(.DEPTH(DEPTH), .NUM_SLOTS(NUM_SLOTS)) dut (
      .clk                         (clk),
      .reset                       (reset),
      .io_kill                     (io_kill),
      .io_brupdate_resolve_mask    (io_brupdate_resolve_mask),
      .io_wakeup_ports_0_valid     (w0v),
      .io_wakeup_ports_0_bits_pdst (w0p),
      .io_wakeup_ports_1_valid     (w1v),
      .io_wakeup_ports_1_bits_pdst (w1p),
      .bus                         (bus),
      .io_count                    (io_count)
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
      ,
      .io_stall_cnt                (io_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [6:0]  pdst, prs1, prs2;
      logic        b1, b2;
      logic [11:0] br;
   } uop_t;

   uop_t q[$];
   int   m_stall = 0;

   function automatic bit wk(input logic [6:0] prs);
      return (w0v && w0p == prs) || (w1v && w1p == prs);
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         m_stall = 0;
      end else if (run) begin
         logic [NUM_SLOTS-1:0] e_we;
         bit   do_pop, do_push, found;
         uop_t h, n;
         e_we   = '0;
         found  = 0;
         do_pop = (q.size() > 0) && !io_kill && (bus.io_slot_valid != {NUM_SLOTS{1'b1}});
         if (do_pop)
            for (int i = 0; i < NUM_SLOTS; i++)
               if (!found && !bus.io_slot_valid[i]) begin
                  e_we[i] = 1'b1;
                  found   = 1;
               end
         do_push = bus.io_dis_valid && (q.size() < DEPTH) && !io_kill;

         check("ready", bus.io_dis_ready, q.size() < DEPTH);
         check("count", io_count, q.size());
         check("slot_we", bus.io_slot_we, e_we);
         if (q.size() > 0) begin
            h = q[0];
            check("out_pdst", bus.io_out_uop_pdst, h.pdst);
            check("out_prs1", bus.io_out_uop_prs1, h.prs1);
            check("out_prs2", bus.io_out_uop_prs2, h.prs2);
            check("out_b1", bus.io_out_uop_prs1_busy, h.b1 && !wk(h.prs1));
            check("out_b2", bus.io_out_uop_prs2_busy, h.b2 && !wk(h.prs2));
            check("out_br", bus.io_out_uop_br_mask, h.br & ~io_brupdate_resolve_mask);
         end else begin
            check("out_pdst_idle", bus.io_out_uop_pdst, 0);
            check("out_br_idle", bus.io_out_uop_br_mask, 0);
            check("out_b1_idle", bus.io_out_uop_prs1_busy, 0);
         end
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
         check("stall_cnt", io_stall_cnt, m_stall);
         if (io_kill) m_stall = 0;
         else if (q.size() > 0 && bus.io_slot_valid == {NUM_SLOTS{1'b1}} && m_stall < 16'hFFFF)
            m_stall++;
`endif
         for (int i = 0; i < q.size(); i++) begin
            if (wk(q[i].prs1)) q[i].b1 = 1'b0;
            if (wk(q[i].prs2)) q[i].b2 = 1'b0;
            q[i].br = q[i].br & ~io_brupdate_resolve_mask;
         end
         if (io_kill) q.delete();
         else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
               n.pdst = bus.io_dis_uop_pdst;
               n.prs1 = bus.io_dis_uop_prs1;
               n.prs2 = bus.io_dis_uop_prs2;
               n.b1   = bus.io_dis_uop_prs1_busy && !wk(n.prs1);
               n.b2   = bus.io_dis_uop_prs2_busy && !wk(n.prs2);
               n.br   = bus.io_dis_uop_br_mask & ~io_brupdate_resolve_mask;
               q.push_back(n);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic enq(input logic [6:0] pdst, input logic [6:0] p1, input logic b1,
                      input logic [6:0] p2, input logic b2, input logic [11:0] br);
      bus.io_dis_valid         = 1'b1;
      bus.io_dis_uop_pdst      = pdst;
      bus.io_dis_uop_prs1      = p1;
      bus.io_dis_uop_prs1_busy = b1;
      bus.io_dis_uop_prs2      = p2;
      bus.io_dis_uop_prs2_busy = b2;
      bus.io_dis_uop_br_mask   = br;
   endtask

   task automatic idle();
      bus.io_dis_valid = 1'b0;
      io_kill = 1'b0;
      io_brupdate_resolve_mask = '0;
      w0v = 1'b0; w1v = 1'b0; w0p = '0; w1p = '0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      enq(0, 0, 0, 0, 0, 0);
      bus.io_dis_valid  = 1'b0;
      bus.io_slot_valid = '0;
      repeat (3) tick();
      check("rst_count", io_count, 0);
      check("rst_ready", bus.io_dis_ready, 1);
      check("rst_we", bus.io_slot_we, 0);
      check("rst_pdst", bus.io_out_uop_pdst, 0);
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
      check("rst_stall", io_stall_cnt, 0);
`endif
      reset = 1'b1;
      run   = 1'b1;

      // single uop through to slot 0
      enq(5, 1, 1, 2, 1, 0);
      at_neg(); check("t1_no_fwd", bus.io_slot_we, 0);
      tick(); idle();
      at_neg(); check("t1_we", bus.io_slot_we, 8'h01); check("t1_pdst", bus.io_out_uop_pdst, 5);
      check("t1_cnt1", io_count, 1);
      tick();
      at_neg(); check("t1_cnt0", io_count, 0);
      tick();

      // slots full for 10 cycles, then slot 3 frees
      bus.io_slot_valid = 8'hFF;
      enq(7, 0, 0, 0, 0, 0);
      tick(); idle();
      repeat (10) tick();
      bus.io_slot_valid = 8'hF7;
      at_neg(); check("t2_we", bus.io_slot_we, 8'h08);
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
      check("t2_stall", io_stall_cnt, 10);
`endif
      tick();

      // fill, stall, drain across wrap
      bus.io_slot_valid = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         enq(7'(10 + k), 0, 0, 0, 0, 0);
         tick();
      end
      enq(14, 0, 0, 0, 0, 0);
      at_neg(); check("t3_ready", bus.io_dis_ready, 0); check("t3_count", io_count, 4);
      tick();
      idle();
      bus.io_slot_valid = 8'h00;
      for (int k = 0; k < 4; k++) begin
         at_neg();
         check("t3_drain", bus.io_out_uop_pdst, 10 + k);
         if (k == 0) check("t3_ready_pop", bus.io_dis_ready, 0);
         if (k == 1) check("t3_ready_rise", bus.io_dis_ready, 1);
         tick();
      end
      at_neg(); check("t3_empty", io_count, 0);
      tick();

      // wakeup on held entry, on output, and on enqueue
      bus.io_slot_valid = 8'hFF;
      enq(20, 9, 1, 4, 1, 0);
      tick(); idle();
      w1v = 1'b1; w1p = 9;
      at_neg(); check("t4_out_b1", bus.io_out_uop_prs1_busy, 0); check("t4_out_b2", bus.io_out_uop_prs2_busy, 1);
      tick(); idle();
      enq(21, 6, 1, 3, 1, 0);
      w0v = 1'b1; w0p = 3;
      at_neg(); check("t4_stored_b1", bus.io_out_uop_prs1_busy, 0);
      tick(); idle();
      bus.io_slot_valid = 8'h00;
      at_neg(); check("t4_head20", bus.io_out_uop_pdst, 20);
      tick();
      at_neg(); check("t4_head21", bus.io_out_uop_pdst, 21);
      check("t4_enq_b2", bus.io_out_uop_prs2_busy, 0); check("t4_enq_b1", bus.io_out_uop_prs1_busy, 1);
      tick();

      // branch resolve
      bus.io_slot_valid = 8'hFF;
      enq(30, 0, 0, 0, 0, 12'h00C);
      tick(); idle();
      io_brupdate_resolve_mask = 12'h004;
      at_neg(); check("t5_br_comb", bus.io_out_uop_br_mask, 12'h008);
      tick();
      io_brupdate_resolve_mask = 12'h000;
      bus.io_slot_valid = 8'h00;
      at_neg(); check("t5_br_stored", bus.io_out_uop_br_mask, 12'h008);
      tick();

      // kill with a same-cycle enqueue
      bus.io_slot_valid = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         enq(7'(40 + k), 0, 0, 0, 0, 0);
         tick();
      end
      enq(7'h55, 0, 0, 0, 0, 0);
      io_kill = 1'b1;
      bus.io_slot_valid = 8'h00;
      at_neg(); check("t6_kill_we", bus.io_slot_we, 0);
      tick(); idle();
      at_neg(); check("t6_count", io_count, 0); check("t6_we", bus.io_slot_we, 0);
      tick();
      repeat (2) tick();

      // back-to-back enqueue and dequeue
      enq(50, 0, 0, 0, 0, 0);
      tick();
      enq(51, 0, 0, 0, 0, 0);
      at_neg(); check("t7_cnt", io_count, 1); check("t7_pdst", bus.io_out_uop_pdst, 50);
      tick();
      enq(52, 0, 0, 0, 0, 0);
      at_neg(); check("t7_cnt2", io_count, 1); check("t7_pdst2", bus.io_out_uop_pdst, 51);
      tick(); idle();
      repeat (2) tick();

      // asynchronous reset mid-operation
      bus.io_slot_valid = 8'hFF;
      enq(60, 0, 0, 0, 0, 0);
      tick();
      enq(61, 0, 0, 0, 0, 0);
      tick(); idle();
      reset = 1'b0;
      #1;
      check("t8_async_cnt", io_count, 0);
      check("t8_async_ready", bus.io_dis_ready, 1);
`ifdef DISPATCH_BUFFER_STALL_CNT_EN
      check("t8_async_stall", io_stall_cnt, 0);
`endif
      tick();
      reset = 1'b1;
      bus.io_slot_valid = 8'h00;
      repeat (3) tick();

      run = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
